sram_access_ctrl: RTL and testbench

//  Access sequencer that drives the SRAM macro's row decoder and array strobes.

---
 rtl/sram_access_ctrl_if.sv | 26 ++
 rtl/sram_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Request/response bus between the chip I/O logic and the SRAM access sequencer.
interface sram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // Chip I/O side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  // Sequencer side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: one request at a time, drives precharge, wordline,
// write-driver and sense-amp strobes, then a one-cycle response. All outputs
// are flops loaded from the next-state decode, so strobes never glitch.
module sram_access_ctrl #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int PRECH_CYCLES = 2,
  parameter int WL_CYCLES    = 2,
  parameter int SENSE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_access_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] row_addr,
  output logic                  wl_enable,
  output logic                  precharge_en,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] bl_wdata,
  output logic                  sense_en,
  input  logic [DATA_WIDTH-1:0] sa_data
);

  // Phase counter must hold the longest phase length.
  localparam int CNT_MAX_PW = (PRECH_CYCLES > WL_CYCLES) ? PRECH_CYCLES : WL_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_PW > SENSE_CYCLES) ? CNT_MAX_PW : SENSE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_WORDLINE  = 3'd2,
    ST_SENSE     = 3'd3,
    ST_RECOVER   = 3'd4,
    ST_RESPOND   = 3'd5
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic                  capture_s;
  logic                  accept_s;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] row_addr_r;
  logic [DATA_WIDTH-1:0] bl_wdata_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_we_r;
  logic                  prech_r;
  logic                  wl_r;
  logic                  wr_r;
  logic                  sense_r;

  // ready_r is high exactly while the FSM sits in IDLE.
  assign accept_s = bus.req_valid & ready_r;

  // Next-state and phase-counter decode; counters run down to 1 then advance.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_PRECHARGE;
          cnt_s   = CNT_W'(PRECH_CYCLES);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRECHARGE: begin
        if (cnt_r == CNT_W'(1)) begin
          state_s = ST_WORDLINE;
          cnt_s   = CNT_W'(WL_CYCLES);
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_WORDLINE: begin
        if (cnt_r == CNT_W'(1)) begin
          if (we_r) begin
            state_s = ST_RECOVER;
          end else begin
            state_s = ST_SENSE;
            cnt_s   = CNT_W'(SENSE_CYCLES);
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_SENSE: begin
        if (cnt_r == CNT_W'(1)) begin
          state_s   = ST_RECOVER;
          capture_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_RECOVER: state_s = ST_RESPOND;
      ST_RESPOND: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, latched request, captured data and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      we_r        <= 1'b0;
      row_addr_r  <= '0;
      bl_wdata_r  <= '0;
      rdata_r     <= '0;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      prech_r     <= 1'b0;
      wl_r        <= 1'b0;
      wr_r        <= 1'b0;
      sense_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ready_r     <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESPOND);
      rsp_we_r    <= (state_s == ST_RESPOND) & we_r;
      prech_r     <= (state_s == ST_PRECHARGE);
      wl_r        <= (state_s == ST_WORDLINE) | (state_s == ST_SENSE);
      wr_r        <= (state_s == ST_WORDLINE) & we_r;
      sense_r     <= (state_s == ST_SENSE);
      // Address/data only move on accept, i.e. while the wordline is off.
      if (accept_s) begin
        we_r       <= bus.req_we;
        row_addr_r <= bus.req_addr;
        bl_wdata_r <= bus.req_wdata;
      end
      if (capture_s) begin
        rdata_r <= sa_data;
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_we    = rsp_we_r;
  assign bus.rsp_rdata = rdata_r;
  assign row_addr      = row_addr_r;
  assign bl_wdata      = bl_wdata_r;
  assign precharge_en  = prech_r;
  assign wl_enable     = wl_r;
  assign write_en      = wr_r;
  assign sense_en      = sense_r;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: default timing plus 1/1/1 and 3/4/2
// timing variants, all driven from the same request stimulus.
module tb_sram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] sa_data;

  logic [2:0]       pc, wl, wr, se, rv;
  logic [2:0][7:0]  rd;
  logic [5:0]       row0, row1, row2;
  logic [7:0]       bw0, bw1, bw2;

  int n_cmp = 0;
  int n_bad = 0;

  sram_access_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus0 ();
  sram_access_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus1 ();
  sram_access_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus2 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_we    = req_we;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_valid = req_valid;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_valid = req_valid;
  assign bus2.req_we    = req_we;
  assign bus2.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;

  assign rv = {bus2.rsp_valid, bus1.rsp_valid, bus0.rsp_valid};
  assign rd[0] = bus0.rsp_rdata;
  assign rd[1] = bus1.rsp_rdata;
  assign rd[2] = bus2.rsp_rdata;

  sram_access_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .row_addr(row0), .wl_enable(wl[0]), .precharge_en(pc[0]), .write_en(wr[0]),
    .bl_wdata(bw0), .sense_en(se[0]), .sa_data(sa_data)
  );

  sram_access_ctrl #(.PRECH_CYCLES(1), .WL_CYCLES(1), .SENSE_CYCLES(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .row_addr(row1), .wl_enable(wl[1]), .precharge_en(pc[1]), .write_en(wr[1]),
    .bl_wdata(bw1), .sense_en(se[1]), .sa_data(sa_data)
  );

  sram_access_ctrl #(.PRECH_CYCLES(3), .WL_CYCLES(4), .SENSE_CYCLES(2)) u_slow (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .row_addr(row2), .wl_enable(wl[2]), .precharge_en(pc[2]), .write_en(wr[2]),
    .bl_wdata(bw2), .sense_en(se[2]), .sa_data(sa_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter and log of accept edges on the default-timing instance.
  int cyc = 0;
  int acc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus0.req_valid && bus0.req_ready) acc_q.push_back(cyc);
  end

  // Strobe-safety monitor over all three instances.
  int viol = 0;
  logic [2:0] wl_prev = 3'b000;
  function automatic int count_bad();
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      if (pc[i] && wl[i]) n++;
      if (pc[i] && wl_prev[i]) n++;
      if (wr[i] && se[i]) n++;
    end
    return n;
  endfunction
  always @(negedge clk) begin
    viol    <= viol + count_bad();
    wl_prev <= wl;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle traces of one access (bit k = cycle k, cycle 0 = accept cycle).
  logic [15:0] m_pc [3];
  logic [15:0] m_wl [3];
  logic [15:0] m_se [3];
  logic [15:0] m_wr [3];
  logic [15:0] m_rv [3];
  logic [7:0]  rd_rv [3];
  logic [15:0] m_rdy;
  logic [5:0]  a_row [16];
  logic [7:0]  a_rd  [16];
  logic [7:0]  a_bw  [16];
  logic        a_rwe [16];

  task automatic rec(input int k);
    for (int i = 0; i < 3; i++) begin
      m_pc[i][k] = pc[i];
      m_wl[i][k] = wl[i];
      m_se[i][k] = se[i];
      m_wr[i][k] = wr[i];
      m_rv[i][k] = rv[i];
      if (rv[i]) rd_rv[i] = rd[i];
    end
    m_rdy[k] = bus0.req_ready;
    a_row[k] = row0;
    a_rd[k]  = bus0.rsp_rdata;
    a_bw[k]  = bw0;
    a_rwe[k] = bus0.rsp_we;
  endtask

  // Present one request in cycle 0, then scramble the idle inputs while tracing.
  task automatic run_access(input logic we, input logic [5:0] addr, input logic [7:0] wd, input int ncyc);
    for (int i = 0; i < 3; i++) begin
      m_pc[i] = 16'h0000; m_wl[i] = 16'h0000; m_se[i] = 16'h0000;
      m_wr[i] = 16'h0000; m_rv[i] = 16'h0000; rd_rv[i] = 8'h00;
    end
    m_rdy = 16'h0000;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    rec(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_addr = 6'h15; req_wdata = 8'hEE;
      rec(k);
    end
  endtask

  // Directed test sequence.
  initial begin
    int base;
    logic row_ok;
    logic rv_seen;
    logic nxt_we;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 6'h00;
    req_wdata = 8'h00; sa_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_ready", bus0.req_ready, 1);
    check_eq("rst_strobes", {pc[0], wl[0], wr[0], se[0]}, 0);
    check_eq("rst_rsp", {bus0.rsp_valid, bus0.rsp_we}, 0);
    check_eq("rst_row_wdata", {row0, bw0}, 0);
    check_eq("rst_rdata", bus0.rsp_rdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: read 0x2A
    sa_data = 8'hC3;
    run_access(1'b0, 6'h2A, 8'h00, 10);
    check_eq("t1_prech", m_pc[0], 16'h0006);
    check_eq("t1_wl", m_wl[0], 16'h0038);
    check_eq("t1_sense", m_se[0], 16'h0020);
    check_eq("t1_write", m_wr[0], 16'h0000);
    check_eq("t1_rsp_valid", m_rv[0], 16'h0080);
    check_eq("t1_ready", m_rdy, 16'h0701);
    check_eq("t1_row", a_row[3], 6'h2A);
    check_eq("t1_rdata_pre", a_rd[5], 8'h00);
    check_eq("t1_rdata", a_rd[7], 8'hC3);
    check_eq("t1_rsp_we", a_rwe[7], 0);

    // 2: write 0x3F / 0x5A
    sa_data = 8'h99;
    run_access(1'b1, 6'h3F, 8'h5A, 10);
    check_eq("t2_prech", m_pc[0], 16'h0006);
    check_eq("t2_wl", m_wl[0], 16'h0018);
    check_eq("t2_write", m_wr[0], 16'h0018);
    check_eq("t2_sense", m_se[0], 16'h0000);
    check_eq("t2_rsp_valid", m_rv[0], 16'h0040);
    check_eq("t2_ready", m_rdy, 16'h0781);
    check_eq("t2_rsp_we", a_rwe[6], 1);
    check_eq("t2_bl_wdata", {a_bw[3], a_bw[4]}, 16'h5A5A);
    check_eq("t2_row", a_row[3], 6'h3F);
    check_eq("t2_rdata_held", a_rd[6], 8'hC3);

    // 3: request changes while busy are ignored
    sa_data = 8'h77;
    base = acc_q.size();
    row_ok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h2A;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (row0 !== 6'h2A) row_ok = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h11 + 6'(k);
    end
    @(negedge clk);
    check_eq("t3_row_hold", row_ok, 1);
    check_eq("t3_row_idle", row0, 6'h2A);
    check_eq("t3_one_accept", acc_q.size() - base, 1);
    check_eq("t3_rdata", bus0.rsp_rdata, 8'h77);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h19;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("t3_next_accept", acc_q.size() - base, 2);
    check_eq("t3_row_new", row0, 6'h19);
    repeat (12) @(negedge clk);

    // 4: back-to-back alternating read/write
    sa_data = 8'h4B;
    base = acc_q.size();
    nxt_we = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = nxt_we; req_addr = nxt_we ? 6'h3F : 6'h00;
      req_wdata = 8'hA0 + 8'(k);
      if (bus0.req_ready) nxt_we = ~nxt_we;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("t4_n_accept", acc_q.size() - base, 6);
    if (acc_q.size() - base >= 5) begin
      check_eq("t4_gap_rd", acc_q[base+1] - acc_q[base], 8);
      check_eq("t4_gap_wr", acc_q[base+2] - acc_q[base+1], 7);
      check_eq("t4_gap_rd2", acc_q[base+3] - acc_q[base+2], 8);
      check_eq("t4_gap_wr2", acc_q[base+4] - acc_q[base+3], 7);
    end
    repeat (12) @(negedge clk);
    check_eq("t4_safety", viol, 0);

    // 5: reset during WORDLINE of a write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h05; req_wdata = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_in_wl", {wl[0], wr[0]}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_strobes", {pc[0], wl[0], wr[0], se[0]}, 0);
    check_eq("t5_ready", bus0.req_ready, 1);
    check_eq("t5_row_wdata", {row0, bw0}, 0);
    check_eq("t5_rdata", bus0.rsp_rdata, 0);
    rst_n = 1'b1;
    rv_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rv[0]) rv_seen = 1'b1;
    end
    check_eq("t5_no_rsp", rv_seen, 0);
    check_eq("t5_ready_after", bus0.req_ready, 1);

    // 6: timing variants 1/1/1 and 3/4/2
    sa_data = 8'h3C;
    run_access(1'b0, 6'h09, 8'h00, 15);
    check_eq("t6_fast_prech", m_pc[1], 16'h0002);
    check_eq("t6_fast_wl", m_wl[1], 16'h000C);
    check_eq("t6_fast_sense", m_se[1], 16'h0008);
    check_eq("t6_fast_rsp", m_rv[1], 16'h0020);
    check_eq("t6_fast_rdata", rd_rv[1], 8'h3C);
    check_eq("t6_slow_prech", m_pc[2], 16'h000E);
    check_eq("t6_slow_wl", m_wl[2], 16'h03F0);
    check_eq("t6_slow_sense", m_se[2], 16'h0300);
    check_eq("t6_slow_rsp", m_rv[2], 16'h0800);
    check_eq("t6_slow_rdata", rd_rv[2], 8'h3C);
    check_eq("t6_safety", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
